// File: rtl/misao_alu_pkg.sv
// Opcode/width encodings and small helpers shared by the nibble-serial ALU path.
package misao_alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    INC = 4'd2,
    DEC = 4'd3,
    AND = 4'd4,
    OR  = 4'd5,
    XOR = 4'd6,
    INV = 4'd7,
    SHL = 4'd8,
    SHR = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    UL   = 2'd0,
    LK8  = 2'd1,
    LK16 = 2'd2
  } width_mode_t;

  // Encoding 3 is reserved and behaves as UL.
  function automatic logic [2:0] nibbles_for(input logic [1:0] mode);
    case (mode)
      LK8:     return 3'd2;
      LK16:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic first_cin(input alu_op_t op, input logic cen, input logic carry_in);
    case (op)
      ADD, SUB, SHL, SHR: return cen & carry_in;
      INC, DEC:           return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

  function automatic logic is_logic_op(input alu_op_t op);
    return op inside {AND, OR, XOR, INV};
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bundle between the decode/control FSM (master) and the nibble sequencer (slave).
interface alu_nibble_sequencer_if;
  import misao_alu_pkg::*;

  logic        start;
  alu_op_t     op;
  logic [1:0]  mode;
  logic        cen;
  logic        carry_in;
  logic [15:0] a;
  logic [15:0] b;
  logic        kill;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic        carry_out;

  modport master (
    output start, op, mode, cen, carry_in, a, b, kill,
    input  ready, done, result, carry_out
  );

  modport slave (
    input  start, op, mode, cen, carry_in, a, b, kill,
    output ready, done, result, carry_out
  );

endinterface

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit ALU slice; SUB/DEC report borrow in cout, shifts pass the edge bit through cin/cout.
module alu_nibble_slice
  import misao_alu_pkg::*;
(
  input  alu_op_t    op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);

  logic [4:0] sum;

  always_comb begin
    y    = 4'd0;
    cout = 1'b0;
    sum  = 5'd0;
    case (op)
      ADD, INC: begin
        sum  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        y    = sum[3:0];
        cout = sum[4];
      end
      SUB, DEC: begin
        // Bit 4 of the 5-bit difference goes high exactly when a borrow is needed.
        sum  = {1'b0, a} - {1'b0, b} - {4'd0, cin};
        y    = sum[3:0];
        cout = sum[4];
      end
      AND: y = a & b;
      OR:  y = a | b;
      XOR: y = a ^ b;
      INV: y = ~a;
      SHL: begin
        y    = {a[2:0], cin};
        cout = a[3];
      end
      SHR: begin
        y    = {cin, a[3:1]};
        cout = a[0];
      end
      default: begin
        y    = 4'd0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Runs one ALU op over 1/2/4 nibbles through an external slice; start-to-done is N+1 cycles.
// ready is low only while running; kill aborts a run without disturbing the last committed result.
module alu_nibble_sequencer
  import misao_alu_pkg::*;
#(
  parameter int NIB  = 4,
  parameter int MAXN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_nibble_sequencer_if.slave bus,
  output alu_op_t               slice_op,
  output logic [NIB-1:0]        slice_a,
  output logic [NIB-1:0]        slice_b,
  output logic                  slice_cin,
  input  logic [NIB-1:0]        slice_y,
  input  logic                  slice_cout
);

  localparam int W     = NIB * MAXN;
  localparam int IDX_W = $clog2(MAXN);
  localparam int CNT_W = $clog2(MAXN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  alu_op_t            op_q, op_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               chain_q, chain_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q, cout_d;
  logic               accept;
  logic [CNT_W-1:0]   n_req;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    chain_d  = chain_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    n_req    = CNT_W'(nibbles_for(bus.mode));
    accept   = bus.start && (state_q != S_RUN) && !bus.kill;

    case (state_q)
      S_RUN: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d[idx_q*NIB +: NIB] = slice_y;
          chain_d = slice_cout;
          cnt_d   = cnt_q + CNT_W'(1);
          idx_d   = (op_q == SHR) ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
          // The working register only becomes visible once every nibble has landed.
          if (cnt_d == n_q) begin
            state_d  = S_DONE;
            result_d = acc_d;
            cout_d   = is_logic_op(op_q) ? 1'b0 : slice_cout;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_RUN;
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = (bus.op == INC || bus.op == DEC) ? '0 : bus.b;
          n_d     = n_req;
          cnt_d   = '0;
          idx_d   = (bus.op == SHR) ? IDX_W'(n_req - CNT_W'(1)) : '0;
          chain_d = first_cin(bus.op, bus.cen, bus.carry_in);
          acc_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= ADD;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      chain_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      chain_q  <= chain_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    slice_op  = ADD;
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state_q == S_RUN) begin
      slice_op  = op_q;
      slice_a   = a_q[idx_q*NIB +: NIB];
      slice_b   = b_q[idx_q*NIB +: NIB];
      slice_cin = chain_q;
    end
  end

  assign bus.ready     = (state_q != S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for the nibble sequencer with the combinational slice attached beside it.
module tb_alu_nibble_sequencer
  import misao_alu_pkg::*;
;

  logic       clk;
  logic       rst;
  alu_op_t    slice_op;
  logic [3:0] slice_a, slice_b, slice_y;
  logic       slice_cin, slice_cout;
  int         vectors;
  int         fails;

  alu_nibble_sequencer_if bus();

  alu_nibble_sequencer #(.NIB(4), .MAXN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .slice_op   (slice_op),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_y    (slice_y),
    .slice_cout (slice_cout)
  );

  alu_nibble_slice u_slice (
    .op   (slice_op),
    .a    (slice_a),
    .b    (slice_b),
    .cin  (slice_cin),
    .y    (slice_y),
    .cout (slice_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_op_t     op;
    logic [1:0]  mode;
    logic        cen;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        co;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-word arithmetic reference: the operation is applied to the full N*4-bit operand at once.
  function automatic void model(input alu_op_t op, input logic [1:0] mode, input logic cen,
                                input logic cin, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic co);
    int     w;
    longint mask, av, bv, ci, t;
    w    = (mode == 2'd1) ? 8 : (mode == 2'd2) ? 16 : 4;
    mask = (longint'(1) << w) - 1;
    av   = longint'(a) & mask;
    bv   = longint'(b) & mask;
    ci   = ((op inside {ADD, SUB, SHL, SHR}) && cen && cin) ? 1 : 0;
    co   = 1'b0;
    case (op)
      ADD: begin t = av + bv + ci; co = ((t >> w) & 1) != 0; end
      SUB: begin t = av - bv - ci; co = (t < 0); end
      INC: begin t = av + 1;       co = ((t >> w) & 1) != 0; end
      DEC: begin t = av - 1;       co = (t < 0); end
      AND: t = av & bv;
      OR:  t = av | bv;
      XOR: t = av ^ bv;
      INV: t = ~av;
      SHL: begin t = (av << 1) | ci;        co = ((av >> (w - 1)) & 1) != 0; end
      SHR: begin t = (av >> 1) | (ci << (w - 1)); co = (av & 1) != 0; end
      default: t = 0;
    endcase
    r = 16'(t & mask);
  endfunction

  task automatic run_op(input alu_op_t op, input logic [1:0] mode, input logic cen, input logic cin,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic ec);
    int         n, fi, cyc;
    bit         got;
    logic [3:0] fa;
    logic       fc, ecin;
    n    = (mode == 2'd1) ? 2 : (mode == 2'd2) ? 4 : 1;
    fi   = (op == SHR) ? n - 1 : 0;
    ecin = (op == INC || op == DEC) ? 1'b1 : ((op inside {ADD, SUB, SHL, SHR}) ? (cen & cin) : 1'b0);
    @(negedge clk);
    bus.op = op; bus.mode = mode; bus.cen = cen; bus.carry_in = cin;
    bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0; got = 0; fa = 4'd0; fc = 1'b0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        fa = slice_a;
        fc = slice_cin;
      end
      if (bus.done) got = 1;
    end
    check("latency", 32'(cyc), 32'(n + 1));
    check("first_slice_a", 32'(fa), 32'(a[fi*4 +: 4]));
    check("first_cin", 32'(fc), 32'(ecin));
    check("result", 32'(bus.result), 32'(er));
    check("carry_out", 32'(bus.carry_out), 32'(ec));
  endtask

  initial begin
    logic [15:0] er;
    logic        ec;
    bit          done_seen;

    vectors = 0;
    fails   = 0;
    tbl[0]  = '{ADD, 2'd0, 1'b1, 1'b0, 16'h0003, 16'h0005, 16'h0008, 1'b0};
    tbl[1]  = '{ADD, 2'd2, 1'b0, 1'b1, 16'h0001, 16'hFFFF, 16'h0000, 1'b1};
    tbl[2]  = '{SUB, 2'd1, 1'b0, 1'b0, 16'h0010, 16'h0001, 16'h000F, 1'b0};
    tbl[3]  = '{SHR, 2'd1, 1'b1, 1'b1, 16'h000F, 16'h0000, 16'h0087, 1'b1};
    tbl[4]  = '{DEC, 2'd0, 1'b0, 1'b0, 16'h0003, 16'h000A, 16'h0002, 1'b0};
    tbl[5]  = '{DEC, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h000F, 1'b1};
    tbl[6]  = '{INC, 2'd1, 1'b0, 1'b0, 16'h00FF, 16'h0055, 16'h0000, 1'b1};
    tbl[7]  = '{XOR, 2'd3, 1'b1, 1'b1, 16'hABCD, 16'h1234, 16'h0009, 1'b0};
    tbl[8]  = '{INV, 2'd2, 1'b0, 1'b0, 16'h00F0, 16'h0000, 16'hFF0F, 1'b0};
    tbl[9]  = '{SHL, 2'd2, 1'b1, 1'b1, 16'h8001, 16'h0000, 16'h0003, 1'b1};
    tbl[10] = '{SUB, 2'd2, 1'b1, 1'b1, 16'h0000, 16'h0001, 16'hFFFE, 1'b1};
    tbl[11] = '{AND, 2'd1, 1'b1, 1'b1, 16'hF3C5, 16'h0F0F, 16'h0005, 1'b0};
    tbl[12] = '{OR,  2'd2, 1'b0, 1'b0, 16'hA000, 16'h0505, 16'hA505, 1'b0};
    tbl[13] = '{SHL, 2'd0, 1'b0, 1'b1, 16'h0009, 16'h0000, 16'h0002, 1'b1};

    rst = 1'b0;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = ADD; bus.mode = 2'd0;
    bus.cen = 1'b0; bus.carry_in = 1'b0; bus.a = 16'd0; bus.b = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_carry", 32'(bus.carry_out), 32'd0);
    check("rst_slice", {22'd0, slice_op, slice_a, slice_b, slice_cin, 1'b0}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++)
      run_op(tbl[i].op, tbl[i].mode, tbl[i].cen, tbl[i].cin, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].co);

    // Abort an LK16 op in its second RUN cycle; the previous result must survive.
    run_op(ADD, 2'd1, 1'b0, 1'b0, 16'h0012, 16'h0034, 16'h0046, 1'b0);
    @(negedge clk);
    bus.op = ADD; bus.mode = 2'd2; bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cen = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1 bus.kill = 1'b0;
    @(negedge clk);
    check("kill_ready", 32'(bus.ready), 32'd1);
    check("kill_result", 32'(bus.result), 32'h0046);
    check("kill_carry", 32'(bus.carry_out), 32'd0);
    done_seen = bus.done;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) done_seen = 1;
    end
    check("kill_no_done", 32'(done_seen), 32'd0);

    // kill and start together while idle: nothing is accepted.
    @(negedge clk);
    bus.op = ADD; bus.mode = 2'd0; bus.a = 16'h0001; bus.b = 16'h0001; bus.start = 1'b1; bus.kill = 1'b1;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.kill = 1'b0; end
    @(negedge clk);
    check("kill_beats_start", 32'(bus.ready), 32'd1);

    // start held through the DONE cycle launches the second op with no idle gap.
    @(negedge clk);
    bus.op = ADD; bus.mode = 2'd0; bus.cen = 1'b0; bus.a = 16'h0003; bus.b = 16'h0005; bus.start = 1'b1;
    @(posedge clk);
    #1 begin bus.a = 16'h0009; bus.b = 16'h0009; end
    @(negedge clk);
    @(negedge clk);
    check("b2b_first_done", 32'(bus.done), 32'd1);
    check("b2b_first_result", 32'(bus.result), 32'h0008);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("b2b_no_gap_busy", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("b2b_second_done", 32'(bus.done), 32'd1);
    check("b2b_second_result", {15'd0, bus.carry_out, bus.result}, {15'd0, 1'b1, 16'h0002});

    for (int i = 0; i < 40; i++) begin
      alu_op_t     rop;
      logic [1:0]  rmode;
      logic        rcen, rcin;
      logic [15:0] ra, rb;
      rop   = alu_op_t'($urandom_range(0, 9));
      rmode = 2'($urandom_range(0, 3));
      rcen  = 1'($urandom_range(0, 1));
      rcin  = 1'($urandom_range(0, 1));
      ra    = 16'($urandom);
      rb    = 16'($urandom);
      model(rop, rmode, rcen, rcin, ra, rb, er, ec);
      run_op(rop, rmode, rcen, rcin, ra, rb, er, ec);
    end

    // Asynchronous reset in the middle of a run clears everything at once.
    @(negedge clk);
    bus.op = SUB; bus.mode = 2'd2; bus.a = 16'h1234; bus.b = 16'h0F0F; bus.cen = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(bus.ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", {15'd0, bus.carry_out, bus.result}, 32'd0);
    check("midrst_slice", {22'd0, slice_op, slice_a, slice_b, slice_cin, 1'b0}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(ADD, 2'd1, 1'b1, 1'b1, 16'h007F, 16'h0001, 16'h0081, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Multi-cycle controller that runs one MISA-O ALU operation over 1, 2 or 4 nibbles according to width mode: UL = 4-bit, LK8 = 8-bit, LK16 = 16-bit.
- Drives an external combinational 4-bit ALU slice one nibble per cycle and chains carry/borrow between nibbles.
- Assembles the 16-bit result and returns it with a start/ready/done handshake.
- Sits between the core decode/control FSM and the nibble ALU.

Parameters:
- NIB, 4, slice width in bits (fixed; documents intent).
- MAXN, 4, maximum nibbles per operation (LK16).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted when start && ready.
- op  in  4  ALU opcode (package enum).
- mode  in  2  0=UL, 1=LK8, 2=LK16, 3=treated as UL.
- cen  in  1  carry enable.
- carry_in  in  1  current carry flag.
- a  in  16  operand A (ACC).
- b  in  16  operand B (RS0).
- kill  in  1  synchronous abort.
- ready  out  1  idle and able to accept.
- done  out  1  one-cycle result-valid pulse.
- result  out  16  assembled result.
- carry_out  out  1  final carry/borrow.
- slice_op  out  4  op to slice.
- slice_a  out  4  nibble of A.
- slice_b  out  4  nibble of B.
- slice_cin  out  1  chained carry in.
- slice_y  in  4  slice result (combinational).
- slice_cout  in  1  slice carry/borrow out.

Behaviour:
- Reset values: state=IDLE, ready=1, done=0, result=0, carry_out=0, slice_* outputs=0.
- States:
  - IDLE: ready=1.
  - RUN: ready=0; counter idx runs over N = 1/2/4 nibbles.
  - DONE: one cycle; done=1, ready=1.
- Accept: on the edge where start && ready, latch op, mode, a, b, cen, carry_in; clear the result register; go to RUN.
- RUN: each cycle, capture slice_y into result nibble idx and slice_cout into the chain carry.
  - After the Nth nibble, go to DONE.
- Latency: accept edge T; slice active T..T+N-1; done high in cycle T+N. Start-to-done = N+1 cycles.
- Back-to-back: start in the DONE cycle is accepted; DONE goes directly to RUN.
- Nibble order:
  - idx 0 up to N-1 for all ops except SHR.
  - SHR runs N-1 down to 0.
- First-nibble carry in:
  - ADD/SUB, SHL/SHR: cen ? carry_in : 0.
  - INC/DEC: forced 1, and b forced to 0.
  - Logic ops (AND, OR, XOR, INV): 0.
- Later nibbles take the previous slice_cout.
- Slice contract:
  - SUB: a-b-cin, cout = borrow.
  - SHL: cin enters bit0, cout = bit3.
  - SHR: cin enters bit3, cout = bit0.
  - Logic ops: cout = 0.
- carry_out = last captured cout; for logic ops it is 0.
- result and carry_out hold until the next accept. Result bits above the width are 0; operand bits above the width are ignored.
- slice_* outputs are combinational from latched state and idx; they are 0 outside RUN.
- kill:
  - In RUN: go to IDLE next edge, no done, result unchanged from the last completed op (captured partial nibbles discarded via shadow register).
  - In IDLE/DONE: blocks acceptance that cycle; kill beats start.
- Async reset mid-RUN: immediate return to reset values.

Decomposition:
- Package misao_alu_pkg:
  - alu_op_t enum: ADD=0, SUB=1, INC=2, DEC=3, AND=4, OR=5, XOR=6, INV=7, SHL=8, SHR=9.
  - width_mode_t enum: UL, LK8, LK16.
  - nibbles_for(mode) function.
- Sub-module alu_nibble_slice: the combinational slice, instantiated beside the sequencer at core level and in the bench; not inside the sequencer.

Test Plan:
- UL ADD, a=3, b=5, cen=1, carry_in=0 -> slice active 1 cycle; done at T+1; result=0x0008, carry_out=0.
- LK16 ADD, a=0x0001, b=0xFFFF, cen=0 -> slice idx 0,1,2,3; done at T+4; result=0x0000, carry_out=1.
- LK8 SUB, a=0x10, b=0x01 -> result=0x0F, carry_out=0 (borrow propagated nibble0->nibble1).
- LK8 SHR, a=0x0F, cen=1, carry_in=1 -> slice order idx1 then idx0; result=0x87, carry_out=1.
- UL DEC, a=3 -> result=0x2, carry_out=0. Then UL DEC, a=0 -> result=0xF, carry_out=1.
- kill at second RUN cycle of LK16 op -> no done; ready=1 next cycle; previous result retained. Separately, assert rst mid-RUN -> all outputs 0 immediately. Start asserted in the DONE cycle -> accepted with no idle gap.
